// File: rtl/uart_rx.sv
// uart_rx -- 8N1 asynchronous serial receiver, 16x oversampled.
//
// Recovers frames (start, DATA_SIZE data bits LSB first, stop) from the rx
// line using the shared 16x baud tick. Each word is presented on data_out
// with a one-clock rx_done_tick; frame_err travels with it and flags a stop
// bit that sampled low. A word with a framing error is still delivered.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   s_tick        one-clk pulse at 16x baud rate
//   rx            serial line, asynchronous to clk, idle high
//   data_out      last received word (holds until the next frame)
//   rx_done_tick  one-clk pulse: data_out / frame_err valid
//   frame_err     stop bit of the last word sampled low
module uart_rx #(
    parameter int DATA_SIZE      = 8,
    parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 rx_done_tick,
    output logic                 frame_err
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [BIT_COUNT_SIZE-1:0] LAST_BIT = BIT_COUNT_SIZE'(DATA_SIZE - 1);
    localparam logic [BIT_COUNT_SIZE-1:0] BIT_ONE  = BIT_COUNT_SIZE'(1);

    state_t                    state, state_n;
    logic [3:0]                sample_count, sample_count_n;
    logic [BIT_COUNT_SIZE-1:0] bit_count, bit_count_n;
    logic [DATA_SIZE-1:0]      shift_reg, shift_reg_n;
    logic                      wait_high, wait_high_n;
    logic [DATA_SIZE-1:0]      data_out_n;
    logic                      frame_err_n;
    logic                      rx_done_n;
    logic                      rx_meta, rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // reset release never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sample_count <= '0;
            bit_count    <= '0;
            shift_reg    <= '0;
            wait_high    <= 1'b0;
            data_out     <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            sample_count <= sample_count_n;
            bit_count    <= bit_count_n;
            shift_reg    <= shift_reg_n;
            wait_high    <= wait_high_n;
            data_out     <= data_out_n;
            frame_err    <= frame_err_n;
            rx_done_tick <= rx_done_n;
        end
    end

    always_comb begin
        state_n        = state;
        sample_count_n = sample_count;
        bit_count_n    = bit_count;
        shift_reg_n    = shift_reg;
        wait_high_n    = wait_high;
        data_out_n     = data_out;
        frame_err_n    = frame_err;
        rx_done_n      = 1'b0;

        if (s_tick) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n        = START;
                        sample_count_n = '0;
                    end
                end
                START: begin
                    // Mid start bit: a line back high here was a glitch.
                    if (sample_count == 4'd7) begin
                        if (!rx_s) begin
                            state_n        = DATA;
                            sample_count_n = '0;
                            bit_count_n    = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        sample_count_n = sample_count + 4'd1;
                    end
                end
                DATA: begin
                    if (sample_count == 4'd15) begin
                        sample_count_n = '0;
                        shift_reg_n    = {rx_s, shift_reg[DATA_SIZE-1:1]};
                        if (bit_count == LAST_BIT) begin
                            bit_count_n = '0;
                            state_n     = STOP;
                        end else begin
                            bit_count_n = bit_count + BIT_ONE;
                        end
                    end else begin
                        sample_count_n = sample_count + 4'd1;
                    end
                end
                STOP: begin
                    if (wait_high) begin
                        // Hold off until the line recovers so a stuck-low
                        // or break condition yields only one word.
                        if (rx_s) begin
                            wait_high_n = 1'b0;
                            state_n     = IDLE;
                        end
                    end else if (sample_count == 4'd15) begin
                        data_out_n     = shift_reg;
                        frame_err_n    = ~rx_s;
                        rx_done_n      = 1'b1;
                        sample_count_n = '0;
                        if (rx_s) state_n     = IDLE;
                        else      wait_high_n = 1'b1;
                    end else begin
                        sample_count_n = sample_count + 4'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
